// File: rtl/micro_pkg.sv
// micro_pkg: shared types for the microprogrammed control sequencer.
// Microcode states, ALU op codes, microword layout and opcodes.
package micro_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    EXEC_I = 4'd3,
    EXEC_U = 4'd4,
    ADDR   = 4'd5,
    MEM_RD = 4'd6,
    MEM_WR = 4'd7,
    WB_ALU = 4'd8,
    WB_MEM = 4'd9,
    BRANCH = 4'd10,
    JAL    = 4'd11,
    JALR   = 4'd12,
    HALT   = 4'd15
  } upc_e;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  typedef enum logic [2:0] {
    NX_SEQ,
    NX_DISPATCH,
    NX_FETCH,
    NX_WAIT_I,
    NX_WAIT_D,
    NX_STAY
  } next_e;

  // How the top derives alu_op for this microword
  typedef enum logic [1:0] {
    AK_ADD,
    AK_R,
    AK_I,
    AK_BR
  } alu_k_e;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_rd;
    logic       dmem_wr;
    logic       ir_wr;
    logic       pc_wr;
    logic [1:0] pc_sel;
    logic       reg_wr;
    logic [1:0] wb_sel;
    logic       a_pc_u;
    logic       src_b;
    alu_k_e     alu_k;
    logic       br;
    logic       retire;
    logic       halted;
    next_e      nxt;
    upc_e       tgt;
  } microword_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  function automatic microword_t mw_idle();
    microword_t w;
    w       = '0;
    w.alu_k = AK_ADD;
    w.nxt   = NX_FETCH;
    w.tgt   = FETCH;
    return w;
  endfunction

  // Word presented while reset is held: fetch request only
  function automatic microword_t mw_reset();
    microword_t w;
    w          = mw_idle();
    w.imem_req = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/micro_rom.sv
// micro_rom: combinational microword ROM and opcode dispatch table.
// Unmapped uPC values read as the HALT word.
module micro_rom
  import micro_pkg::*;
#(
  parameter int UPC_W = 4
) (
  input  logic [UPC_W-1:0] i_upc,
  input  logic [6:0]       i_op,
  input  logic [1:0]       i_f3h,
  output microword_t       o_mw,
  output upc_e             o_disp
);

  // Microword contents per uPC
  always_comb begin
    o_mw = mw_idle();
    case (i_upc)
      UPC_W'(FETCH): begin
        o_mw.imem_req = 1'b1;
        o_mw.ir_wr    = 1'b1;
        o_mw.pc_wr    = 1'b1;
        o_mw.nxt      = NX_WAIT_I;
        o_mw.tgt      = DECODE;
      end
      UPC_W'(DECODE): o_mw.nxt = NX_DISPATCH;
      UPC_W'(EXEC_R): begin
        o_mw.alu_k = AK_R;
        o_mw.nxt   = NX_SEQ;
        o_mw.tgt   = WB_ALU;
      end
      UPC_W'(EXEC_I): begin
        o_mw.alu_k = AK_I;
        o_mw.src_b = 1'b1;
        o_mw.nxt   = NX_SEQ;
        o_mw.tgt   = WB_ALU;
      end
      UPC_W'(EXEC_U): begin
        o_mw.a_pc_u = 1'b1;
        o_mw.src_b  = 1'b1;
        o_mw.nxt    = NX_SEQ;
        o_mw.tgt    = WB_ALU;
      end
      UPC_W'(ADDR): begin
        o_mw.src_b = 1'b1;
        o_mw.nxt   = NX_DISPATCH;
      end
      UPC_W'(MEM_RD): begin
        o_mw.dmem_rd = 1'b1;
        o_mw.src_b   = 1'b1;
        o_mw.nxt     = NX_WAIT_D;
        o_mw.tgt     = WB_MEM;
      end
      UPC_W'(MEM_WR): begin
        o_mw.dmem_wr = 1'b1;
        o_mw.src_b   = 1'b1;
        o_mw.retire  = 1'b1;
        o_mw.nxt     = NX_WAIT_D;
      end
      UPC_W'(WB_ALU): begin
        o_mw.reg_wr = 1'b1;
        o_mw.retire = 1'b1;
      end
      UPC_W'(WB_MEM): begin
        o_mw.reg_wr = 1'b1;
        o_mw.wb_sel = 2'd1;
        o_mw.retire = 1'b1;
      end
      UPC_W'(BRANCH): begin
        o_mw.alu_k  = AK_BR;
        o_mw.br     = 1'b1;
        o_mw.pc_wr  = 1'b1;
        o_mw.pc_sel = 2'd1;
        o_mw.retire = 1'b1;
      end
      UPC_W'(JAL): begin
        o_mw.reg_wr = 1'b1;
        o_mw.wb_sel = 2'd2;
        o_mw.pc_wr  = 1'b1;
        o_mw.pc_sel = 2'd1;
        o_mw.retire = 1'b1;
      end
      UPC_W'(JALR): begin
        o_mw.reg_wr = 1'b1;
        o_mw.wb_sel = 2'd2;
        o_mw.pc_wr  = 1'b1;
        o_mw.pc_sel = 2'd2;
        o_mw.src_b  = 1'b1;
        o_mw.retire = 1'b1;
      end
      default: begin
        o_mw.halted = 1'b1;
        o_mw.nxt    = NX_STAY;
        o_mw.tgt    = HALT;
      end
    endcase
  end

  // Dispatch target; ADDR re-dispatches to the load or store access
  always_comb begin
    o_disp = HALT;
    if (i_upc == UPC_W'(ADDR)) begin
      o_disp = i_op[5] ? MEM_WR : MEM_RD;
    end else begin
      case (i_op)
        OP_R:     o_disp = EXEC_R;
        OP_I:     o_disp = EXEC_I;
        OP_LUI:   o_disp = EXEC_U;
        OP_AUIPC: o_disp = EXEC_U;
        OP_LOAD:  o_disp = ADDR;
        OP_STORE: o_disp = ADDR;
        OP_BR:    o_disp = (i_f3h == 2'b01) ? HALT : BRANCH;
        OP_JAL:   o_disp = JAL;
        OP_JALR:  o_disp = JALR;
        default:  o_disp = HALT;
      endcase
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: uPC, memory-wait watchdog, instret and ALU decode.
// Outputs are combinational in uPC, instr and the handshakes.
module micro_sequencer
  import micro_pkg::*;
#(
  parameter int UPC_W    = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        zero,
  input  logic        alu_lsb,
  output logic        imem_req,
  output logic        dmem_rd,
  output logic        dmem_wr,
  output logic        ir_wr,
  output logic        pc_wr,
  output logic [1:0]  pc_sel,
  output logic        reg_wr,
  output logic [1:0]  wb_sel,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [3:0]  alu_op,
  output logic        retire,
  output logic [31:0] instret,
  output logic        halted
);

  logic [UPC_W-1:0] r_upc;
  logic [7:0]       r_cnt;
  logic [31:0]      r_instret;
  microword_t       w_rom;
  microword_t       w_mw;
  upc_e             w_disp;
  logic [UPC_W-1:0] w_nxt;
  logic             w_go;
  logic             w_wait;
  logic             w_taken;
  logic             w_expire;
  alu_op_e          w_alu;
  logic             w_unused_bits;

  assign w_unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

  micro_rom #(.UPC_W(UPC_W)) u_rom (
    .i_upc  (r_upc),
    .i_op   (instr[6:0]),
    .i_f3h  (instr[14:13]),
    .o_mw   (w_rom),
    .o_disp (w_disp)
  );

  // Reset overrides the ROM so a held reset abandons the instruction
  always_comb w_mw = rst ? w_rom : mw_reset();

  // Handshake qualifier for strobes in wait words
  always_comb begin
    w_go = 1'b1;
    case (w_mw.nxt)
      NX_WAIT_I: w_go = imem_ready;
      NX_WAIT_D: w_go = dmem_ready;
      default:   w_go = 1'b1;
    endcase
  end

  assign w_wait   = ((w_mw.nxt == NX_WAIT_I) ||
                     (w_mw.nxt == NX_WAIT_D)) && !w_go;
  assign w_expire = (r_cnt == 8'(WAIT_MAX - 1));
  assign w_taken  = (instr[14] ? alu_lsb : zero) ^ instr[12];

  // Next uPC from the microword next field
  always_comb begin
    w_nxt = r_upc;
    case (w_mw.nxt)
      NX_SEQ:      w_nxt = UPC_W'(w_mw.tgt);
      NX_DISPATCH: w_nxt = UPC_W'(w_disp);
      NX_FETCH:    w_nxt = UPC_W'(FETCH);
      NX_WAIT_I, NX_WAIT_D: begin
        if (w_go)
          w_nxt = UPC_W'(w_mw.tgt);
        else if (w_expire)
          w_nxt = UPC_W'(HALT);
      end
      default:     w_nxt = r_upc;
    endcase
  end

  // ALU operation from funct3/instr[30]
  always_comb begin
    w_alu = ALU_ADD;
    case (w_mw.alu_k)
      AK_R, AK_I: begin
        case (instr[14:12])
          3'b000: w_alu = (w_mw.alu_k == AK_R && instr[30]) ?
                          ALU_SUB : ALU_ADD;
          3'b001: w_alu = ALU_SLL;
          3'b010: w_alu = ALU_SLT;
          3'b011: w_alu = ALU_SLTU;
          3'b100: w_alu = ALU_XOR;
          3'b101: w_alu = instr[30] ? ALU_SRA : ALU_SRL;
          3'b110: w_alu = ALU_OR;
          default: w_alu = ALU_AND;
        endcase
      end
      AK_BR: begin
        case (instr[14:13])
          2'b10:   w_alu = ALU_SLT;
          2'b11:   w_alu = ALU_SLTU;
          default: w_alu = ALU_SUB;
        endcase
      end
      default: w_alu = ALU_ADD;
    endcase
  end

  // uPC, wait counter and retired count
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_upc     <= UPC_W'(FETCH);
      r_cnt     <= '0;
      r_instret <= '0;
    end else begin
      r_upc <= w_nxt;
      if (w_nxt != r_upc)
        r_cnt <= '0;
      else if (w_wait)
        r_cnt <= r_cnt + 8'd1;
      if (retire)
        r_instret <= r_instret + 32'd1;
    end
  end

  assign imem_req  = w_mw.imem_req;
  assign dmem_rd   = w_mw.dmem_rd;
  assign dmem_wr   = w_mw.dmem_wr;
  assign ir_wr     = w_mw.ir_wr & w_go;
  assign pc_wr     = w_mw.pc_wr & w_go & (!w_mw.br | w_taken);
  assign pc_sel    = w_mw.pc_sel;
  assign reg_wr    = w_mw.reg_wr & w_go;
  assign wb_sel    = w_mw.wb_sel;
  assign alu_src_a = w_mw.a_pc_u & ~instr[5];
  assign alu_src_b = w_mw.src_b;
  assign alu_op    = w_alu;
  assign retire    = w_mw.retire & w_go;
  assign instret   = r_instret;
  assign halted    = w_mw.halted;

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: per-cycle expected-output tables built from
// instruction-level rules, plus reset/halt/wrap corner sequences.
module tb_micro_sequencer;

  localparam int WMAX = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        imem_ready, dmem_ready, zero, alu_lsb;
  logic        imem_req, dmem_rd, dmem_wr, ir_wr, pc_wr;
  logic [1:0]  pc_sel, wb_sel;
  logic        reg_wr, alu_src_a, alu_src_b, retire, halted;
  logic [3:0]  alu_op;
  logic [31:0] instret;

  always #5 clk = ~clk;

  micro_sequencer #(.UPC_W(4), .WAIT_MAX(WMAX)) dut (
    .clk(clk), .rst(rst), .instr(instr),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .zero(zero), .alu_lsb(alu_lsb),
    .imem_req(imem_req), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
    .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_sel(pc_sel),
    .reg_wr(reg_wr), .wb_sel(wb_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .retire(retire),
    .instret(instret), .halted(halted)
  );

  typedef struct packed {
    logic       imem_req;
    logic       dmem_rd;
    logic       dmem_wr;
    logic       ir_wr;
    logic       pc_wr;
    logic [1:0] pc_sel;
    logic       reg_wr;
    logic [1:0] wb_sel;
    logic       src_a;
    logic       src_b;
    logic [3:0] alu_op;
    logic       retire;
    logic       halted;
  } ov_t;

  typedef struct {
    logic ri;
    logic rd;
    ov_t  e;
    ov_t  m;
  } vec_t;

  vec_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_instret;
  ov_t         act;

  assign act = {imem_req, dmem_rd, dmem_wr, ir_wr, pc_wr, pc_sel,
                reg_wr, wb_sel, alu_src_a, alu_src_b, alu_op,
                retire, halted};

  function automatic ov_t en_mask();
    ov_t m;
    m = '0;
    m.imem_req = 1; m.dmem_rd = 1; m.dmem_wr = 1; m.ir_wr = 1;
    m.pc_wr = 1; m.reg_wr = 1; m.retire = 1; m.halted = 1;
    return m;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] alu_exp(logic [31:0] ins, bit is_r);
    logic [3:0] tab [8];
    logic [3:0] r;
    tab = '{4'b0010, 4'b0100, 4'b1000, 4'b1001,
            4'b0011, 4'b0101, 4'b0001, 4'b0000};
    r = tab[ins[14:12]];
    if (ins[14:12] == 3'b000 && is_r && ins[30]) r = 4'b0110;
    if (ins[14:12] == 3'b101 && ins[30]) r = 4'b0111;
    return r;
  endfunction

  function automatic logic br_taken(logic [2:0] f3, logic z, logic l);
    case (f3)
      3'b000: return z;
      3'b001: return !z;
      3'b100, 3'b110: return l;
      3'b101, 3'b111: return !l;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] br_alu(logic [2:0] f3);
    if (!f3[2]) return 4'b0110;
    return f3[1] ? 4'b1001 : 4'b1000;
  endfunction

  task automatic push(input logic ri, input logic rd,
                      input ov_t e, input ov_t m);
    vec_t v;
    v.ri = ri; v.rd = rd; v.e = e; v.m = m | en_mask();
    q.push_back(v);
  endtask

  task automatic push_halt(input int n);
    ov_t e;
    for (int k = 0; k < n; k++) begin
      e = '0; e.halted = 1;
      push(rb(), rb(), e, '0);
    end
  endtask

  // Expected cycle table for one instruction
  task automatic build(input logic [31:0] ins, input int di,
                       input int dd, input logic z, input logic l,
                       input int nh);
    ov_t e, m;
    for (int k = 0; k < di; k++) begin
      e = '0; e.imem_req = 1;
      push(1'b0, rb(), e, '0);
    end
    e = '0; e.imem_req = 1; e.ir_wr = 1; e.pc_wr = 1;
    m = '0; m.pc_sel = '1;
    push(1'b1, rb(), e, m);
    e = '0;
    push(rb(), rb(), e, '0);
    case (ins[6:0])
      7'b0110011, 7'b0010011: begin
        e = '0; m = '0;
        e.alu_op = alu_exp(ins, ins[5]); m.alu_op = '1;
        e.src_a = 0; m.src_a = 1;
        e.src_b = !ins[5]; m.src_b = 1;
        push(rb(), rb(), e, m);
        e = '0; m = '0; e.reg_wr = 1; e.retire = 1; m.wb_sel = '1;
        push(rb(), rb(), e, m);
      end
      7'b0110111, 7'b0010111: begin
        e = '0; m = '0; e.alu_op = 4'b0010; m.alu_op = '1;
        push(rb(), rb(), e, m);
        e = '0; m = '0; e.reg_wr = 1; e.retire = 1; m.wb_sel = '1;
        push(rb(), rb(), e, m);
      end
      7'b0000011, 7'b0100011: begin
        e = '0; m = '0; e.alu_op = 4'b0010; e.src_b = 1;
        m.alu_op = '1; m.src_b = 1;
        push(rb(), rb(), e, m);
        e = '0;
        if (ins[5]) e.dmem_wr = 1; else e.dmem_rd = 1;
        for (int k = 0; k < dd; k++) push(rb(), 1'b0, e, '0);
        if (ins[5]) e.retire = 1;
        push(rb(), 1'b1, e, '0);
        if (!ins[5]) begin
          e = '0; m = '0; e.reg_wr = 1; e.wb_sel = 1; e.retire = 1;
          m.wb_sel = '1;
          push(rb(), rb(), e, m);
        end
      end
      7'b1100011: begin
        if (ins[14:13] == 2'b01) begin
          push_halt(nh);
        end else begin
          e = '0; m = '0;
          e.pc_wr = br_taken(ins[14:12], z, l);
          e.pc_sel = 1; e.retire = 1; e.alu_op = br_alu(ins[14:12]);
          m.pc_sel = '1; m.alu_op = '1;
          push(rb(), rb(), e, m);
        end
      end
      7'b1101111, 7'b1100111: begin
        e = '0; m = '0;
        e.reg_wr = 1; e.wb_sel = 2; e.pc_wr = 1; e.retire = 1;
        e.pc_sel = ins[3] ? 2'd1 : 2'd2;
        m.wb_sel = '1; m.pc_sel = '1;
        if (!ins[3]) begin
          e.src_b = 1; e.alu_op = 4'b0010;
          m.src_b = 1; m.alu_op = '1;
        end
        push(rb(), rb(), e, m);
      end
      default: push_halt(nh);
    endcase
  endtask

  task automatic play(input logic [31:0] ins, input logic z,
                      input logic l, input string nm);
    instr = ins; zero = z; alu_lsb = l;
    for (int i = 0; i < q.size(); i++) begin
      imem_ready = q[i].ri;
      dmem_ready = q[i].rd;
      @(negedge clk);
      checks++;
      if ((act & q[i].m) !== (q[i].e & q[i].m)) begin
        errors++;
        $display("FAIL %s step %0d: got %h want %h mask %h",
                 nm, i, act, q[i].e, q[i].m);
      end
      if (q[i].e.retire) m_instret = m_instret + 32'd1;
      @(posedge clk); #1;
    end
    q.delete();
  endtask

  task automatic chk_instret(input string nm);
    checks++;
    if (instret !== m_instret) begin
      errors++;
      $display("FAIL %s: instret got %h want %h", nm, instret, m_instret);
    end
  endtask

  task automatic reset_check(input string nm);
    ov_t e;
    rst = 1'b0; imem_ready = 1; dmem_ready = 1; zero = 1; alu_lsb = 1;
    @(negedge clk);
    e = '0; e.imem_req = 1; e.alu_op = 4'b0010;
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: outputs got %h want %h", nm, act, e);
    end
    @(posedge clk); #1;
    rst = 1'b1; imem_ready = 0; dmem_ready = 0;
    m_instret = '0;
    chk_instret({nm, "_instret"});
  endtask

  task automatic run(input logic [31:0] ins, input int di, input int dd,
                     input logic z, input logic l, input string nm);
    build(ins, di, dd, z, l, 2);
    play(ins, z, l, nm);
    chk_instret({nm, "_instret"});
  endtask

  initial begin
    logic [31:0] r, ins;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [2:0]  brf [6];
    ov_t         e;
    brf = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    rst = 1'b0; instr = '0; imem_ready = 0; dmem_ready = 0;
    zero = 0; alu_lsb = 0; m_instret = '0;
    @(posedge clk); #1;
    reset_check("reset");

    run(32'h002081B3, 0, 0, 0, 0, "add");
    run(32'h0000A283, 0, 3, 0, 0, "lw_wait3");
    run(32'h00208463, 0, 0, 1, 0, "beq_taken");
    run(32'h00208463, 0, 0, 0, 0, "beq_not");
    run(32'h0020D463, 0, 0, 0, 0, "bge_taken");
    run(32'h0020A023, 2, 1, 0, 0, "sw");
    run(32'h008000EF, 0, 0, 0, 0, "jal");
    run(32'h000080E7, 1, 0, 0, 0, "jalr");
    run(32'h12345037, 0, 0, 0, 0, "lui");
    run(32'h00100093, WMAX - 1, 0, 0, 0, "fetch_ready_last");
    run(32'h0000A283, 0, WMAX - 1, 0, 0, "lw_ready_last");

    build(32'h00000000, 0, 0, 0, 0, 20);
    play(32'h00000000, 0, 0, "illegal_halt");
    reset_check("halt_rst");

    build(32'h0020A463, 0, 0, 0, 0, 3);
    play(32'h0020A463, 0, 0, "bad_branch");
    reset_check("bad_branch_rst");

    for (int k = 0; k < WMAX; k++) begin
      e = '0; e.imem_req = 1;
      push(1'b0, rb(), e, '0);
    end
    push_halt(4);
    play(32'h00100093, 0, 0, "imem_timeout");
    reset_check("timeout_rst");

    build(32'h0020A023, 0, 3, 0, 0, 2);
    void'(q.pop_back());
    void'(q.pop_back());
    play(32'h0020A023, 0, 0, "sw_abort");
    reset_check("sw_abort_rst");
    run(32'h00100093, 1, 0, 0, 0, "after_abort");

    force dut.r_instret = 32'hFFFF_FFFE;
    #1;
    release dut.r_instret;
    m_instret = 32'hFFFF_FFFE;
    run(32'h00100093, 0, 0, 0, 0, "wrap_a");
    run(32'h00100093, 0, 0, 0, 0, "wrap_b");

    for (int n = 0; n < 40; n++) begin
      r = $urandom();
      f3 = r[14:12];
      case ($urandom_range(0, 7))
        0: op = 7'b0110011;
        1: op = 7'b0010011;
        2: op = r[20] ? 7'b0110111 : 7'b0010111;
        3: op = 7'b0000011;
        4: op = 7'b0100011;
        5: begin op = 7'b1100011; f3 = brf[$urandom_range(0, 5)]; end
        6: op = 7'b1101111;
        default: begin op = 7'b1100111; f3 = 3'b000; end
      endcase
      ins = {r[31:15], f3, r[11:7], op};
      run(ins, $urandom_range(0, 3), $urandom_range(0, 3),
          rb(), rb(), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Microprogrammed control sequencer for the multi-cycle RISC-V datapath. It holds a micro-program counter (uPC) that steps through a microcode ROM. It dispatches on the fetched instruction's opcode and drives every datapath enable, mux select and ALU operation. It also owns the instruction/data memory handshakes and a retired-instruction counter. It sits beside the datapath and replaces the single-cycle combinational control decode.

## Interface
Parameters:
- UPC_W, 4, uPC width; ROM depth 2**UPC_W
- WAIT_MAX, 15, max memory-wait cycles before fault; range 1–255

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous and active-low
- instr  in  32  instruction register contents, valid from DECODE onward
- imem_ready  in  1  instruction memory has returned data this cycle
- dmem_ready  in  1  data memory read/write complete this cycle
- zero  in  1  ALU zero flag
- alu_lsb  in  1  ALU result bit 0, the SLT/SLTU outcome
- imem_req  out  1  instruction fetch request
- dmem_rd, dmem_wr  out  1 each  data memory read and write requests
- ir_wr  out  1  load the instruction register
- pc_wr  out  1  update the PC
- pc_sel  out  2  next-PC source: 0 = PC+4, 1 = PC+imm, 2 = ALU result
- reg_wr  out  1  register-file write enable
- wb_sel  out  2  write-back source: 0 = ALU, 1 = memory, 2 = PC+4
- alu_src_a  out  1  ALU A input: 0 = rs1, 1 = PC
- alu_src_b  out  1  ALU B input: 0 = rs2, 1 = immediate
- alu_op  out  4  ALU operation code (package enum)
- retire  out  1  one-cycle pulse when an instruction completes
- instret  out  32  retired-instruction count
- halted  out  1  fault/halt indicator, sticky

## Operation
- Microcode states and their uPC values: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, EXEC_U 4, ADDR 5, MEM_RD 6, MEM_WR 7, WB_ALU 8, WB_MEM 9, BRANCH 10, JAL 11, JALR 12, HALT 15.
- Each microword holds the control outputs plus a next field: SEQ, DISPATCH, FETCH, WAIT_I, WAIT_D or STAY.
- FETCH:
  - imem_req=1.
  - When imem_ready: ir_wr=1, pc_wr=1 with pc_sel=0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE dispatches on opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0110111 / 0010111 → EXEC_U
  - 0000011 → ADDR, then MEM_RD
  - 0100011 → ADDR, then MEM_WR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - any other opcode → HALT
- alu_op decode:
  - EXEC_R and EXEC_I: derived from funct3 and instr[30]. instr[30] applies to EXEC_I only for shifts.
  - ADDR, EXEC_U and JALR: ADD.
  - BRANCH: SUB for BEQ/BNE; SLT for BLT/BGE; SLTU for BLTU/BGEU.
  - funct3 010 or 011 on a branch → HALT.
- EXEC_R and EXEC_I go to WB_ALU. WB_ALU: reg_wr=1, wb_sel=0, retire, then FETCH.
- MEM_RD: dmem_rd=1 until dmem_ready, then WB_MEM. WB_MEM: reg_wr=1, wb_sel=1, retire, then FETCH.
- MEM_WR: dmem_wr=1 until dmem_ready; retire on the ready cycle, then FETCH.
- BRANCH: taken = BEQ zero | BNE !zero | BLT/BLTU alu_lsb | BGE/BGEU !alu_lsb.
  - pc_wr=taken, pc_sel=1, retire, then FETCH.
  - Branch target is PC+imm of the branch itself. The PC adder uses the old-PC register latched at ir_wr.
- JAL: reg_wr=1, wb_sel=2, pc_wr=1, pc_sel=1, retire, then FETCH.
- JALR: same as JAL but pc_sel=2, alu_src_b=1, and result bit 0 cleared by the datapath.
- Memory-wait counter:
  - 8-bit counter, cleared on entry to FETCH, MEM_RD and MEM_WR; increments each cycle spent waiting.
  - Reaching WAIT_MAX without ready → HALT.
  - A ready arriving on the WAIT_MAX cycle wins.
- HALT: every enable and request is 0, halted=1, STAY until reset.
- instret increments on retire and wraps from 0xFFFF_FFFF to 0.

## Timing
- Reset (rst=0 at a clock edge):
  - uPC=FETCH, instret=0, wait counter=0, halted=0.
  - Outputs during reset: imem_req=1, all other enables 0, alu_op=ADD, all selects 0.
- Reset asserted mid-instruction abandons it: no reg_wr or retire is issued. Reset takes priority over all transitions.
- Latency with zero-wait memory (ready in the request cycle):
  - branch / JAL / JALR: 3 cycles
  - R / I / U / store: 4 cycles
  - load: 5 cycles
- Every memory wait cycle adds exactly one cycle.
- All outputs are a combinational function of uPC, instr and the handshake inputs.
- retire is high for exactly one cycle per instruction.
- Request signals hold steady until their ready arrives; the memory sees no bubbles.

## Structure
- Package `micro_pkg`:
  - `upc_e` state enum
  - `alu_op_e`, shared with the ALU: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001
  - `next_e`
  - `microword_t` packed struct
  - opcode constants
- Sub-module `micro_rom`: combinational microword ROM plus opcode dispatch table.
- The sequencer top holds uPC, the wait counter, instret, and the funct3/funct7 ALU decode.

## Test plan
- Reset, then `add x3,x1,x2` with instant ready → states 0,1,2,8. reg_wr high in cycle 4. retire once. instret=1.
- `lw` with dmem_ready delayed 3 cycles → dmem_rd high for 4 cycles, WB_MEM asserts wb_sel=1. Total 8 cycles.
- `beq` with zero=1 → pc_wr=1, pc_sel=1. With zero=0 → pc_wr=0. Both take 3 cycles. `bge` with alu_lsb=0 → taken.
- Opcode 0000000 → HALT, halted=1 persists 20 cycles with all enables 0. rst=0 clears it.
- imem_ready never asserted, WAIT_MAX=15 → HALT on cycle 15. Ready on cycle 15 → normal DECODE instead.
- instret preloaded near 0xFFFF_FFFF via forced retires → wraps to 0. rst=0 during MEM_WR → no retire, uPC=FETCH next cycle.
